// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline skid buffer.
// State encoding doubles as the occupancy count (0, 1 or 2 held entries).
// Optional performance counters are enabled with the STAGE_PERF_EN macro.
package pipe_pkg;

  // Default widths for a typical decode->execute boundary.
  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 180;
  localparam int PERF_W_DEF = 16;

  // Control value presented downstream whenever no entry is valid.
  localparam int unsigned CTRL_NOP = 0;

  // Slot occupancy state.
  // The encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Number of entries held in a given state.
  function automatic logic [1:0] stateOccupancy(input state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable.
// Counts one per enabled cycle and sticks at all-ones instead of wrapping.
// Cleared only by the asynchronous active-low reset.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int W = PERF_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_atMax;

  assign w_atMax = &r_count;

  // Increment on each qualifying cycle until the all-ones ceiling is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && !w_atMax) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_skid_buffer.sv
// Two-entry skid buffer between two pipeline stages (IF/ID, ID/EX, ...).
// The main slot drives the outputs directly; the skid slot catches the one
// entry that can arrive after downstream stalls, so in_ready can be a
// plain register that never looks at out_ready.
// Flush empties both slots; the control vector reads as NOP when idle,
// while the payload keeps its last value to avoid needless toggling.
// Define STAGE_PERF_EN to add stall_cnt / bubble_cnt saturating counters.
module pipe_stage_skid_buffer
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
`ifdef STAGE_PERF_EN
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] bubble_cnt,
`endif
  output logic [1:0]        occupancy
);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_inReady;
  logic [CTRL_W-1:0] r_mainCtrl;
  logic [DATA_W-1:0] r_mainData;
  logic [CTRL_W-1:0] r_skidCtrl;
  logic [DATA_W-1:0] r_skidData;

  logic              w_outValid;
  logic              w_accept;
  logic              w_deliver;
  logic              w_loadMainFromIn;
  logic              w_loadMainFromSkid;
  logic              w_loadSkid;

  assign w_outValid = (r_state != ST_EMPTY);
  assign w_accept   = in_valid && r_inReady;
  assign w_deliver  = w_outValid && out_ready;

  // Next-state and slot-load decisions; flush overrides any handshake.
  always_comb begin
    w_nextState        = r_state;
    w_loadMainFromIn   = 1'b0;
    w_loadMainFromSkid = 1'b0;
    w_loadSkid         = 1'b0;
    if (flush) begin
      w_nextState = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_nextState      = ST_ONE;
            w_loadMainFromIn = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            w_nextState      = ST_ONE;
            w_loadMainFromIn = 1'b1;
          end else if (w_accept) begin
            w_nextState = ST_FULL;
            w_loadSkid  = 1'b1;
          end else if (w_deliver) begin
            w_nextState = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_deliver) begin
            w_nextState        = ST_ONE;
            w_loadMainFromSkid = 1'b1;
          end
        end
        default: begin
          w_nextState = ST_EMPTY;
        end
      endcase
    end
  end

  // State register plus the registered upstream ready derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_inReady <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState != ST_FULL);
    end
  end

  // Main slot: loaded from the input or promoted from the skid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainCtrl <= '0;
      r_mainData <= '0;
    end else if (w_loadMainFromIn) begin
      r_mainCtrl <= in_ctrl;
      r_mainData <= in_data;
    end else if (w_loadMainFromSkid) begin
      r_mainCtrl <= r_skidCtrl;
      r_mainData <= r_skidData;
    end
  end

  // Skid slot: catches the entry accepted while downstream is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skidCtrl <= '0;
      r_skidData <= '0;
    end else if (w_loadSkid) begin
      r_skidCtrl <= in_ctrl;
      r_skidData <= in_data;
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = w_outValid;
  assign out_ctrl  = w_outValid ? r_mainCtrl : CTRL_W'(CTRL_NOP);
  assign out_data  = r_mainData;
  assign occupancy = stateOccupancy(r_state);

`ifdef STAGE_PERF_EN
  logic w_stallCycle;
  logic w_bubbleCycle;

  assign w_stallCycle  = in_valid && !r_inReady;
  assign w_bubbleCycle = !w_outValid && out_ready;

  pipe_sat_counter #(
    .W (PERF_W)
  ) u_stallCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_stallCycle),
    .o_count (stall_cnt)
  );

  pipe_sat_counter #(
    .W (PERF_W)
  ) u_bubbleCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_bubbleCycle),
    .o_count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid_buffer.sv
// Directed bench for pipe_stage_skid_buffer.
// Counter checks are included when STAGE_PERF_EN is defined.
module tb_pipe_stage_skid_buffer;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 180;
  localparam int PERF_W = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef STAGE_PERF_EN
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] bubble_cnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  pipe_stage_skid_buffer #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .PERF_W (PERF_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
`ifdef STAGE_PERF_EN
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .occupancy  (occupancy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all upstream/downstream inputs at once.
  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d, input logic ordy,
                               input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one clock and land 1 unit after the rising edge.
  task automatic stepClock(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single comparison point; every call counts as one test.
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence covering reset, streaming, backpressure, flush.
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 16'h00A5, 180'h11, 1'b0, 1'b0);
    stepClock(2);
    checkOutput("rst_out_valid", 256'(out_valid), 256'd0);
    checkOutput("rst_in_ready",  256'(in_ready),  256'd1);
    checkOutput("rst_occupancy", 256'(occupancy), 256'd0);
    checkOutput("rst_out_ctrl",  256'(out_ctrl),  256'd0);
    checkOutput("rst_out_data",  256'(out_data),  256'd0);

    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_out_valid", 256'(out_valid), 256'd0);
    checkOutput("post_rst_in_ready",  256'(in_ready),  256'd1);

    stepClock(1);
    checkOutput("first_out_valid", 256'(out_valid), 256'd1);
    checkOutput("first_out_ctrl",  256'(out_ctrl),  256'h00A5);
    checkOutput("first_out_data",  256'(out_data),  256'h11);
    checkOutput("first_occupancy", 256'(occupancy), 256'd1);

    applyStimulus(1'b0, 16'h0000, 180'h0, 1'b1, 1'b0);
    stepClock(1);
    checkOutput("drain_out_valid", 256'(out_valid), 256'd0);
    checkOutput("drain_nop_ctrl",  256'(out_ctrl),  256'd0);
    checkOutput("drain_data_held", 256'(out_data),  256'h11);

    // Streaming: one entry per cycle with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, CTRL_W'(16'h0100 + i), DATA_W'(i), 1'b1, 1'b0);
      stepClock(1);
      checkOutput("stream_out_valid", 256'(out_valid), 256'd1);
      checkOutput("stream_out_data",  256'(out_data),  256'(i));
      checkOutput("stream_out_ctrl",  256'(out_ctrl),  256'(16'h0100 + i));
      checkOutput("stream_in_ready",  256'(in_ready),  256'd1);
    end
    applyStimulus(1'b0, 16'h0000, 180'h0, 1'b1, 1'b0);
    stepClock(1);
    checkOutput("stream_end_occ", 256'(occupancy), 256'd0);

    // Backpressure: A and B held, C waits upstream, then order A, B, C.
    applyStimulus(1'b1, 16'h000A, 180'hA, 1'b0, 1'b0);
    stepClock(1);
    checkOutput("bp_a_occ",      256'(occupancy), 256'd1);
    checkOutput("bp_a_in_ready", 256'(in_ready),  256'd1);
    applyStimulus(1'b1, 16'h000B, 180'hB, 1'b0, 1'b0);
    stepClock(1);
    checkOutput("bp_b_occ",      256'(occupancy), 256'd2);
    checkOutput("bp_b_in_ready", 256'(in_ready),  256'd0);
    checkOutput("bp_b_head",     256'(out_data),  256'hA);
    applyStimulus(1'b1, 16'h000C, 180'hC, 1'b0, 1'b0);
    stepClock(1);
    checkOutput("bp_c_occ",  256'(occupancy), 256'd2);
    checkOutput("bp_c_head", 256'(out_data),  256'hA);
    applyStimulus(1'b1, 16'h000C, 180'hC, 1'b1, 1'b0);
    stepClock(1);
    checkOutput("bp_out_b",      256'(out_data),  256'hB);
    checkOutput("bp_out_b_ctrl", 256'(out_ctrl),  256'h000B);
    checkOutput("bp_out_b_occ",  256'(occupancy), 256'd1);
    checkOutput("bp_in_ready",   256'(in_ready),  256'd1);
    stepClock(1);
    checkOutput("bp_out_c",     256'(out_data),  256'hC);
    checkOutput("bp_out_c_occ", 256'(occupancy), 256'd1);
    applyStimulus(1'b0, 16'h0000, 180'h0, 1'b1, 1'b0);
    stepClock(1);
    checkOutput("bp_end_occ", 256'(occupancy), 256'd0);

    // Flush while full with a concurrent offer D that must be dropped.
    applyStimulus(1'b1, 16'h0021, 180'h21, 1'b0, 1'b0);
    stepClock(1);
    applyStimulus(1'b1, 16'h0022, 180'h22, 1'b0, 1'b0);
    stepClock(1);
    checkOutput("fl_pre_occ", 256'(occupancy), 256'd2);
    applyStimulus(1'b1, 16'h00DD, 180'hDD, 1'b0, 1'b1);
    stepClock(1);
    checkOutput("fl_occ",       256'(occupancy), 256'd0);
    checkOutput("fl_out_valid", 256'(out_valid), 256'd0);
    checkOutput("fl_out_ctrl",  256'(out_ctrl),  256'd0);
    checkOutput("fl_in_ready",  256'(in_ready),  256'd1);
    applyStimulus(1'b0, 16'h0000, 180'h0, 1'b1, 1'b0);
    stepClock(2);
    checkOutput("fl_no_d_valid", 256'(out_valid), 256'd0);
    checkOutput("fl_no_d_data",  256'(out_data == 180'hDD), 256'd0);

    // Asynchronous reset in mid-cycle while two entries are held.
    applyStimulus(1'b1, 16'h0031, 180'h31, 1'b0, 1'b0);
    stepClock(1);
    applyStimulus(1'b1, 16'h0032, 180'h32, 1'b0, 1'b0);
    stepClock(1);
    checkOutput("ar_pre_occ", 256'(occupancy), 256'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_occ",       256'(occupancy), 256'd0);
    checkOutput("ar_out_valid", 256'(out_valid), 256'd0);
    checkOutput("ar_in_ready",  256'(in_ready),  256'd1);
    checkOutput("ar_out_ctrl",  256'(out_ctrl),  256'd0);
    checkOutput("ar_out_data",  256'(out_data),  256'd0);
    applyStimulus(1'b0, 16'h0000, 180'h0, 1'b0, 1'b0);
    stepClock(1);
    rst_n = 1'b1;
    stepClock(1);

`ifdef STAGE_PERF_EN
    // Counters: 20 stalled cycles saturate a 4-bit counter at 15.
    checkOutput("perf_stall_rst",  256'(stall_cnt),  256'd0);
    checkOutput("perf_bubble_rst", 256'(bubble_cnt), 256'd0);
    applyStimulus(1'b1, 16'h0041, 180'h41, 1'b0, 1'b0);
    stepClock(2);
    checkOutput("perf_full_occ", 256'(occupancy), 256'd2);
    stepClock(20);
    checkOutput("perf_stall_sat",  256'(stall_cnt),  256'd15);
    checkOutput("perf_bubble_zero", 256'(bubble_cnt), 256'd0);
    applyStimulus(1'b0, 16'h0000, 180'h0, 1'b0, 1'b1);
    stepClock(1);
    applyStimulus(1'b0, 16'h0000, 180'h0, 1'b1, 1'b0);
    stepClock(3);
    checkOutput("perf_bubble_3",     256'(bubble_cnt), 256'd3);
    checkOutput("perf_stall_kept",   256'(stall_cnt),  256'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
